// File: rtl/token_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : token_sched_pkg
//  Description : Shared types and constants for the token round-robin
//                scheduler (FSM state encoding, default decimation ratio).
//  Revision    : 1.0 - initial release
// ============================================================================
package token_sched_pkg;

    // Scheduler operating states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    // Ratio loaded at reset: keep every second token
    localparam int DEFAULT_RATIO = 2;

endpackage : token_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches req starting one
//                position after ptr (wrapping modulo N) and returns the first
//                set bit as a one-hot vector and as an index. onehot is all
//                zero when req is all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] w_cand;
    logic           w_found;

    // Walk the N candidates in priority order: ptr+1, ptr+2, ... ptr (wrapped)
    always_comb begin
        onehot  = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= N; i++) begin
            // ptr < N and i <= N, so one subtraction is enough to wrap
            w_cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(N)) begin
                w_cand = w_cand - (IDX_W+1)'(N);
            end
            if (!w_found && req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                idx     = w_cand[IDX_W-1:0];
            end
        end
        if (w_found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/token_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : token_rr_scheduler
//  Description : Decimates a serial token stream (keeps 1 of every ratio
//                tokens), stores kept tokens in a small bucket and hands them
//                to N_REQ requesters round-robin, one grant pulse per token.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module token_rr_scheduler
    import token_sched_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int RATIO_W    = 4,
    parameter  int BUCKET_MAX = 7,
    localparam int LVL_W      = $clog2(BUCKET_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               a,
    input  logic               cfg_we,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   gnt,
    output logic               drop,
    output logic               cfg_err,
    output logic [LVL_W-1:0]   level,
    output logic               busy
);

    localparam int                 c_IDX_W     = $clog2(N_REQ);
    localparam logic [LVL_W-1:0]   c_LVL_MAX   = LVL_W'(BUCKET_MAX);
    localparam logic [RATIO_W-1:0] c_RATIO_ONE = RATIO_W'(1);
    localparam logic [RATIO_W-1:0] c_RATIO_RST = RATIO_W'(DEFAULT_RATIO);
    localparam logic [c_IDX_W-1:0] c_PTR_RST   = c_IDX_W'(N_REQ - 1);

    // Registered state
    sched_state_t        r_state;
    logic [RATIO_W-1:0]  r_ratio;
    logic [RATIO_W-1:0]  r_tok_cnt;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [N_REQ-1:0]    r_gnt;
    logic                r_drop;
    logic                r_cfg_err;
    logic                r_busy;

    // Next-state / decision wires
    sched_state_t        w_state_nxt;
    logic [RATIO_W-1:0]  w_ratio_nxt;
    logic [RATIO_W-1:0]  w_tok_cnt_nxt;
    logic [LVL_W-1:0]    w_level_nxt;
    logic                w_drop_nxt;
    logic                w_active;
    logic                w_grant;
    logic                w_kept;
    logic [N_REQ-1:0]    w_arb_onehot;
    logic [c_IDX_W-1:0]  w_arb_idx;

    rr_arbiter #(
        .N      (N_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (r_rr_ptr),
        .onehot (w_arb_onehot),
        .idx    (w_arb_idx)
    );

    // Decide this edge's keep/grant and derive every next-state value
    always_comb begin
        w_active      = (r_state == RUN) || (r_state == DRAIN);
        // Grants only come out of tokens already counted in the bucket
        w_grant       = w_active && (r_level != '0) && (|req);
        w_kept        = (r_state == RUN) && a && (r_tok_cnt == (r_ratio - c_RATIO_ONE));

        w_ratio_nxt   = r_ratio;
        w_tok_cnt_nxt = r_tok_cnt;
        if (r_state == IDLE) begin
            if (cfg_we) begin
                w_ratio_nxt   = (cfg_ratio == '0) ? c_RATIO_ONE : cfg_ratio;
                w_tok_cnt_nxt = '0;
            end
        end else if ((r_state == RUN) && a) begin
            w_tok_cnt_nxt = w_kept ? '0 : (r_tok_cnt + c_RATIO_ONE);
        end

        // Simultaneous keep and grant cancel out, even with a full bucket
        w_level_nxt = r_level;
        w_drop_nxt  = 1'b0;
        if (w_kept && !w_grant) begin
            if (r_level == c_LVL_MAX) begin
                w_drop_nxt = 1'b1;
            end else begin
                w_level_nxt = r_level + LVL_W'(1);
            end
        end else if (!w_kept && w_grant) begin
            w_level_nxt = r_level - LVL_W'(1);
        end

        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) w_state_nxt = RUN;
            end
            RUN: begin
                if (!en) w_state_nxt = (r_level != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (en)                     w_state_nxt = RUN;
                else if (w_level_nxt == '0) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Scheduler FSM with all its registered outputs; reset is asynchronous
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ratio   <= c_RATIO_RST;
            r_tok_cnt <= '0;
            r_rr_ptr  <= c_PTR_RST;
            r_level   <= '0;
            r_gnt     <= '0;
            r_drop    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ratio   <= w_ratio_nxt;
            r_tok_cnt <= w_tok_cnt_nxt;
            r_level   <= w_level_nxt;
            r_drop    <= w_drop_nxt;
            r_cfg_err <= cfg_we && (r_state != IDLE);
            r_busy    <= (w_state_nxt != IDLE);
            if (w_grant) begin
                r_gnt    <= w_arb_onehot;
                r_rr_ptr <= w_arb_idx;
            end else begin
                r_gnt    <= '0;
            end
        end
    end

    assign gnt     = r_gnt;
    assign drop    = r_drop;
    assign cfg_err = r_cfg_err;
    assign level   = r_level;
    assign busy    = r_busy;

endmodule : token_rr_scheduler
`default_nettype wire

// File: tb/tb_token_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_token_rr_scheduler
//  Description : Self-checking bench for token_rr_scheduler. A behavioural
//                model (token counter, bucket count, last-winner index)
//                predicts every output after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_token_rr_scheduler;

    localparam int N    = 4;
    localparam int RW   = 4;
    localparam int BMAX = 7;
    localparam int LW   = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic          a;
    logic          cfg_we;
    logic [RW-1:0] cfg_ratio;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          drop;
    logic          cfg_err;
    logic [LW-1:0] level;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = idle, 1 = running, 2 = draining
    int         m_mode;
    int         m_ratio;
    int         m_seen;
    int         m_last;
    int         m_level;
    logic [N-1:0] e_gnt;
    logic       e_drop;
    logic       e_err;
    logic       e_busy;

    token_rr_scheduler #(
        .N_REQ      (N),
        .RATIO_W    (RW),
        .BUCKET_MAX (BMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .cfg_we    (cfg_we),
        .cfg_ratio (cfg_ratio),
        .req       (req),
        .gnt       (gnt),
        .drop      (drop),
        .cfg_err   (cfg_err),
        .level     (level),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_ratio = 2;
        m_seen  = 0;
        m_last  = N - 1;
        m_level = 0;
        e_gnt   = '0;
        e_drop  = 1'b0;
        e_err   = 1'b0;
        e_busy  = 1'b0;
    endtask

    // Predict the effect of the coming clock edge from the current inputs
    task automatic model_step();
        int  winner;
        int  lv;
        int  kept;
        winner = -1;
        kept   = 0;
        if (m_mode != 0 && m_level > 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (winner < 0 && req[c]) winner = c;
            end
        end
        if (m_mode == 1 && a) begin
            m_seen++;
            if (m_seen >= m_ratio) begin
                kept   = 1;
                m_seen = 0;
            end
        end
        lv     = m_level + kept - ((winner >= 0) ? 1 : 0);
        e_drop = 1'b0;
        if (lv > BMAX) begin
            lv     = BMAX;
            e_drop = 1'b1;
        end
        e_gnt = '0;
        if (winner >= 0) begin
            e_gnt[winner] = 1'b1;
            m_last = winner;
        end
        e_err = cfg_we && (m_mode != 0);
        if (m_mode == 0 && cfg_we) begin
            m_ratio = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
            m_seen  = 0;
        end
        case (m_mode)
            0: if (en) m_mode = 1;
            1: if (!en) m_mode = (m_level > 0) ? 2 : 0;
            default: begin
                if (en)           m_mode = 1;
                else if (lv == 0) m_mode = 0;
            end
        endcase
        m_level = lv;
        e_busy  = (m_mode != 0);
    endtask

    task automatic check_outputs();
        check("gnt",     32'(gnt),     32'(e_gnt));
        check("drop",    32'(drop),    32'(e_drop));
        check("cfg_err", 32'(cfg_err), 32'(e_err));
        check("level",   32'(level),   32'(m_level));
        check("busy",    32'(busy),    32'(e_busy));
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            check_outputs();
        end
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset();
        rst = 1'b1;
        #1;
        check("rst_gnt",   32'(gnt),   32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        model_reset();
        rst = 1'b0;
    endtask

    logic [7:0]   halve_pat;
    logic [N-1:0] rr_seq [5];

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        a         = 1'b0;
        cfg_we    = 1'b0;
        cfg_ratio = '0;
        req       = '0;
        model_reset();
        #12;
        check("reset_gnt",     32'(gnt),     32'd0);
        check("reset_drop",    32'(drop),    32'd0);
        check("reset_cfg_err", 32'(cfg_err), 32'd0);
        check("reset_level",   32'(level),   32'd0);
        check("reset_busy",    32'(busy),    32'd0);
        rst = 1'b0;

        // Halving: default ratio 2 keeps tokens 2, 4, 6
        en = 1'b1;
        cyc(1);
        halve_pat = 8'b1111_0011;
        for (int i = 0; i < 8; i++) begin
            a = halve_pat[i];
            cyc(1);
        end
        a = 1'b0;
        check("halve_level", 32'(level), 32'd3);
        check("halve_drop",  32'(drop),  32'd0);
        en  = 1'b0;
        req = 4'b1111;
        cyc(5);
        req = '0;
        check("halve_drained", 32'(level), 32'd0);

        // Ratio 3 programmed in idle, then a rejected write while running
        cfg_ratio = 4'd3;
        cfg_we    = 1'b1;
        cyc(1);
        cfg_we = 1'b0;
        en     = 1'b1;
        cyc(1);
        a = 1'b1;
        cyc(6);
        a = 1'b0;
        check("ratio3_level", 32'(level), 32'd2);
        cfg_ratio = 4'd5;
        cfg_we    = 1'b1;
        cyc(1);
        check("run_cfg_err", 32'(cfg_err), 32'd1);
        cfg_we = 1'b0;
        cyc(1);
        check("cfg_err_pulse", 32'(cfg_err), 32'd0);
        a = 1'b1;
        cyc(3);
        a = 1'b0;
        check("ratio_kept_3", 32'(level), 32'd3);
        en  = 1'b0;
        req = 4'b1111;
        cyc(5);
        req = '0;

        // Round-robin order from a fresh reset, ratio 0 treated as 1
        async_reset();
        cfg_ratio = 4'd0;
        cfg_we    = 1'b1;
        cyc(1);
        cfg_we = 1'b0;
        en     = 1'b1;
        cyc(1);
        a = 1'b1;
        cyc(5);
        a = 1'b0;
        check("ratio0_level", 32'(level), 32'd5);
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("rr_order", 32'(gnt), 32'(rr_seq[i]));
        end
        cyc(1);
        check("rr_empty_gnt",   32'(gnt),   32'd0);
        check("rr_empty_level", 32'(level), 32'd0);

        // Saturation: full bucket drops, then a grant balances every keep
        req = '0;
        a   = 1'b1;
        cyc(10);
        check("sat_level", 32'(level), 32'd7);
        check("sat_drop",  32'(drop),  32'd1);
        req = 4'b0100;
        cyc(4);
        check("full_bal_level", 32'(level), 32'd7);
        check("full_bal_gnt",   32'(gnt),   32'b0100);
        check("full_bal_drop",  32'(drop),  32'd0);

        // Drain with en low, then re-enter RUN from DRAIN
        a = 1'b0;
        cyc(4);
        check("pre_drain_level", 32'(level), 32'd3);
        en  = 1'b0;
        a   = 1'b1;
        req = 4'b0010;
        cyc(4);
        check("drain_idle_busy",  32'(busy),  32'd0);
        check("drain_idle_level", 32'(level), 32'd0);
        req = '0;
        en  = 1'b1;
        cyc(5);
        en  = 1'b0;
        req = 4'b0001;
        cyc(2);
        en  = 1'b1;
        req = '0;
        cyc(3);
        check("redrain_busy", 32'(busy), 32'd1);

        // Reset while grants are flowing
        cyc(4);
        a   = 1'b0;
        req = 4'b1111;
        cyc(1);
        async_reset();
        req = '0;
        en  = 1'b1;
        cyc(1);
        a = 1'b1;
        cyc(4);
        a   = 1'b0;
        req = 4'b1111;
        cyc(1);
        check("post_rst_first", 32'(gnt), 32'b0001);

        // Randomized traffic with occasional config writes and en drops
        for (int i = 0; i < 400; i++) begin
            a         = 1'($urandom_range(0, 1));
            en        = ((i % 60) < 45) ? ($urandom_range(0, 15) != 0) : 1'b0;
            req       = N'($urandom);
            cfg_we    = ($urandom_range(0, 11) == 0);
            cfg_ratio = RW'($urandom_range(0, 5));
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_token_rr_scheduler
`default_nettype wire
